// File: rtl/p3_operand_stage.sv
// -----------------------------------------------------------------------------
// p3_operand_stage
//
// Operand-fetch and sequencing stage in front of the P3 16-bit ALU
// (ALU ops: 00 add, 01 sub, 10 and, 11 not-B; Z = result==0).
//
// It holds an 8 x 16 register file and takes one command at a time over
// cmd_valid/cmd_ready. Each command is sequenced as:
//   IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE
// One command is accepted every 5 cycles at most.
//
// Configuration macro:
//   P3_SHIFTER_EN  defined   : cmd_shift selects none/LSL1/LSR1/ASR1 on B
//                  undefined : no shifter, Bin = B when bsel=0, cmd_shift
//                              has no effect
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_op              ALU operation, latched and driven on ALUop
//   cmd_rn / cmd_rm     A / B source registers
//   cmd_rd              destination register
//   cmd_shift           B shift select (only with P3_SHIFTER_EN)
//   cmd_asel            1: Ain forced to zero
//   cmd_bsel            1: Bin = sign-extended cmd_imm, shifter bypassed
//   cmd_imm             5-bit immediate
//   cmd_wb              1: write C to R[rd] in WB; 0: compare only
//   ext_we/waddr/wdata  external register write port, active in every state
//   Ain, Bin, ALUop     operands and operation to the external ALU
//   alu_out, alu_z      result and zero flag from the external ALU
//   C, Z                result and status registers, captured in EXEC
//   done                high for the single WB cycle
// -----------------------------------------------------------------------------
module p3_operand_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rn,
  input  logic [ADDR_W-1:0] cmd_rm,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [1:0]        cmd_shift,
  input  logic              cmd_asel,
  input  logic              cmd_bsel,
  input  logic [4:0]        cmd_imm,
  input  logic              cmd_wb,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  output logic [1:0]        ALUop,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic [DATA_W-1:0] C,
  output logic              Z,
  output logic              done
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Command fields latched on accept
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] rn_reg;
  logic [ADDR_W-1:0] rm_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic              asel_reg;
  logic              bsel_reg;
  logic [4:0]        imm_reg;
  logic              wb_reg;
`ifdef P3_SHIFTER_EN
  logic [1:0]        shift_reg;
`else
  // cmd_shift has no effect in this build
  logic              unused_shift;
  assign unused_shift = ^cmd_shift;
`endif

  // Datapath registers
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] c_reg;
  logic              z_reg;

  // Register file; cleared by reset, so kept in flops rather than RAM
  logic [DATA_W-1:0] rf [NREG];

  logic              accept;
  logic              wb_we;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] b_shifted;

  assign accept = cmd_valid && (state_reg == IDLE);
  assign wb_we  = (state_reg == WB) && wb_reg;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = RD_A;
      end
      RD_A: state_next = RD_B;
      RD_B: state_next = EXEC;
      EXEC: state_next = WB;
      WB: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch and operand / result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg    <= '0;
      rn_reg    <= '0;
      rm_reg    <= '0;
      rd_reg    <= '0;
      asel_reg  <= 1'b0;
      bsel_reg  <= 1'b0;
      imm_reg   <= '0;
      wb_reg    <= 1'b0;
`ifdef P3_SHIFTER_EN
      shift_reg <= '0;
`endif
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      z_reg     <= 1'b0;
    end else begin
      if (accept) begin
        op_reg    <= cmd_op;
        rn_reg    <= cmd_rn;
        rm_reg    <= cmd_rm;
        rd_reg    <= cmd_rd;
        asel_reg  <= cmd_asel;
        bsel_reg  <= cmd_bsel;
        imm_reg   <= cmd_imm;
        wb_reg    <= cmd_wb;
`ifdef P3_SHIFTER_EN
        shift_reg <= cmd_shift;
`endif
      end
      // Reads take the pre-edge register contents, so an external write on
      // the same edge is not visible to this load.
      if (state_reg == RD_A) a_reg <= rf[rn_reg];
      if (state_reg == RD_B) b_reg <= rf[rm_reg];
      if (state_reg == EXEC) begin
        c_reg <= alu_out;
        z_reg <= alu_z;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file writes: the writeback is issued after the external write
  // so that it takes priority when both target the same register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ext_we) rf[ext_waddr] <= ext_wdata;
      if (wb_we)  rf[rd_reg]    <= c_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand muxes (continuous; only sampled by the ALU result capture in EXEC)
  // ---------------------------------------------------------------------------
  assign imm_ext = {{(DATA_W-5){imm_reg[4]}}, imm_reg};

`ifdef P3_SHIFTER_EN
  always_comb begin
    b_shifted = b_reg;
    unique case (shift_reg)
      2'b01:   b_shifted = {b_reg[DATA_W-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_reg[DATA_W-1:1]};
      2'b11:   b_shifted = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
      default: b_shifted = b_reg;
    endcase
  end
`else
  assign b_shifted = b_reg;
`endif

  assign Ain   = asel_reg ? '0 : a_reg;
  assign Bin   = bsel_reg ? imm_ext : b_shifted;
  assign ALUop = op_reg;
  assign C     = c_reg;
  assign Z     = z_reg;

endmodule

// File: tb/tb_p3_operand_stage.sv
// -----------------------------------------------------------------------------
// Self-checking bench for p3_operand_stage. A combinational ALU model closes
// the loop around the DUT; a transaction-level reference model tracks the
// register file and the command in flight and is compared on every cycle.
// -----------------------------------------------------------------------------
module tb_p3_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rn, cmd_rm, cmd_rd;
  logic [1:0]  cmd_shift;
  logic        cmd_asel, cmd_bsel;
  logic [4:0]  cmd_imm;
  logic        cmd_wb;
  logic        ext_we;
  logic [2:0]  ext_waddr;
  logic [15:0] ext_wdata;
  logic [15:0] Ain, Bin;
  logic [1:0]  ALUop;
  logic [15:0] alu_out;
  logic        alu_z;
  logic [15:0] C;
  logic        Z;
  logic        done;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  always #5 clk = ~clk;

  p3_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd),
    .cmd_shift(cmd_shift), .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel),
    .cmd_imm(cmd_imm), .cmd_wb(cmd_wb),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
    .alu_out(alu_out), .alu_z(alu_z),
    .C(C), .Z(Z), .done(done)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rm;
    logic [2:0] rd;
    logic [1:0] shift;
    logic       asel;
    logic       bsel;
    logic [4:0] imm;
    logic       wb;
  } cmd_t;

  // ---------------- reference arithmetic ----------------
  function automatic logic [15:0] alu_fn(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return ~b;
    endcase
  endfunction

  function automatic logic [15:0] shift_fn(input logic [1:0] sh, input logic [15:0] b);
    logic signed [15:0] sb;
    sb = $signed(b);
`ifdef P3_SHIFTER_EN
    case (sh)
      2'b01:   return b << 1;
      2'b10:   return b >> 1;
      2'b11:   return 16'(sb >>> 1);
      default: return b;
    endcase
`else
    if (sh == 2'b00) return b;
    return b;
`endif
  endfunction

  function automatic logic [15:0] sext_fn(input logic [4:0] imm);
    logic signed [4:0]  s5;
    logic signed [15:0] s16;
    s5  = $signed(imm);
    s16 = s5;
    return s16;
  endfunction

  function automatic logic [15:0] exp_ain(input cmd_t c, input logic [15:0] a);
    return c.asel ? 16'h0000 : a;
  endfunction

  function automatic logic [15:0] exp_bin(input cmd_t c, input logic [15:0] b);
    return c.bsel ? sext_fn(c.imm) : shift_fn(c.shift, b);
  endfunction

  // Environment ALU
  assign alu_out = alu_fn(ALUop, Ain, Bin);
  assign alu_z   = (alu_out == 16'h0000);

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edges since accept: 0 -> A load, 1 -> B load, 2 -> result, 3 -> writeback.
  logic [15:0] m_regs [8];
  logic [15:0] m_a, m_b, m_c;
  logic        m_z;
  bit          m_busy;
  int          m_age;
  cmd_t        m_cmd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
      m_a <= 16'h0; m_b <= 16'h0; m_c <= 16'h0; m_z <= 1'b0;
      m_busy <= 1'b0; m_age <= 0; m_cmd <= '0;
    end else begin
      if (ext_we) m_regs[ext_waddr] <= ext_wdata;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_cmd  <= '{cmd_op, cmd_rn, cmd_rm, cmd_rd, cmd_shift,
                      cmd_asel, cmd_bsel, cmd_imm, cmd_wb};
          m_busy <= 1'b1;
          m_age  <= 0;
        end
      end else begin
        case (m_age)
          0: m_a <= m_regs[m_cmd.rn];
          1: m_b <= m_regs[m_cmd.rm];
          2: begin
            m_c <= alu_fn(m_cmd.op, exp_ain(m_cmd, m_a), exp_bin(m_cmd, m_b));
            m_z <= (alu_fn(m_cmd.op, exp_ain(m_cmd, m_a), exp_bin(m_cmd, m_b)) == 16'h0);
          end
          default: begin
            if (m_cmd.wb) m_regs[m_cmd.rd] <= m_c;  // overrides ext write
            m_busy <= 1'b0;
          end
        endcase
        m_age <= m_age + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("done", 32'(done), 32'(m_busy && m_age == 3));
      chk("C", 32'(C), 32'(m_c));
      chk("Z", 32'(Z), 32'(m_z));
      if (m_busy) chk("ALUop", 32'(ALUop), 32'(m_cmd.op));
      if (m_busy && m_age == 2) begin
        chk("Ain", 32'(Ain), 32'(exp_ain(m_cmd, m_a)));
        chk("Bin", 32'(Bin), 32'(exp_bin(m_cmd, m_b)));
      end
      for (int i = 0; i < 8; i++) begin
        if (dut.rf[i] !== m_regs[i]) chk($sformatf("R%0d", i), 32'(dut.rf[i]), 32'(m_regs[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_cmd(input cmd_t c);
    cmd_op = c.op; cmd_rn = c.rn; cmd_rm = c.rm; cmd_rd = c.rd;
    cmd_shift = c.shift; cmd_asel = c.asel; cmd_bsel = c.bsel;
    cmd_imm = c.imm; cmd_wb = c.wb;
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    @(posedge clk); #1;
    ext_we = 1'b0;
  endtask

  // Called #1 after a rising edge with the DUT idle. Returns the edge index
  // (relative to the accept edge) after which done was first seen and the
  // operands on the ALU during EXEC. Optionally places an external write on
  // the writeback edge.
  task automatic run_cmd(input cmd_t c, input bit hold_valid,
                         input bit ext_on_wb, input logic [2:0] ea,
                         input logic [15:0] ed,
                         output int done_edge,
                         output logic [15:0] ain_x, output logic [15:0] bin_x);
    drive_cmd(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold_valid) cmd_valid = 1'b0;
    done_edge = -1;
    ain_x = 16'hxxxx; bin_x = 16'hxxxx;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin ain_x = Ain; bin_x = Bin; end
      if (done && done_edge < 0) done_edge = k;
      if (done && ext_on_wb) begin
        ext_we = 1'b1; ext_waddr = ea; ext_wdata = ed;
      end else begin
        ext_we = 1'b0;
      end
      if (!done && done_edge >= 0) break;
    end
    if (done_edge < 0) chk("done_timeout", 32'(done_edge), 32'd3);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    cmd_t c;
    int   de;
    logic [15:0] ax, bx;
    logic [15:0] exp_b [3];

    rst_n = 1'b0; cmd_valid = 1'b0; ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0;
    drive_cmd('0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_C", 32'(C), 32'd0);
    chk("rst_Z", 32'(Z), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // add R0+R1 -> R2 on a freshly reset file
    c = '{2'b00, 3'd0, 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1};
    run_cmd(c, 1'b0, 1'b0, 3'd0, 16'h0, de, ax, bx);
    chk("t1_done_edge", 32'(de), 32'd3);
    chk("t1_R2", 32'(dut.rf[2]), 32'h0000);
    chk("t1_Z", 32'(Z), 32'd1);

    // 5 + A = F
    ext_write(3'd0, 16'h0005);
    ext_write(3'd1, 16'h000A);
    run_cmd(c, 1'b0, 1'b0, 3'd0, 16'h0, de, ax, bx);
    chk("t2_Ain", 32'(ax), 32'h0005);
    chk("t2_Bin", 32'(bx), 32'h000A);
    chk("t2_C", 32'(C), 32'h000F);
    chk("t2_Z", 32'(Z), 32'd0);
    chk("t2_R2", 32'(dut.rf[2]), 32'h000F);

    // shifter on B = 8004
    ext_write(3'd1, 16'h8004);
`ifdef P3_SHIFTER_EN
    exp_b[0] = 16'h0008; exp_b[1] = 16'h4002; exp_b[2] = 16'hC002;
`else
    exp_b[0] = 16'h8004; exp_b[1] = 16'h8004; exp_b[2] = 16'h8004;
`endif
    for (int s = 1; s <= 3; s++) begin
      c = '{2'b00, 3'd0, 3'd1, 3'd5, 2'(s), 1'b1, 1'b0, 5'd0, 1'b0};
      run_cmd(c, 1'b0, 1'b0, 3'd0, 16'h0, de, ax, bx);
      chk($sformatf("t3_Bin_sh%0d", s), 32'(bx), 32'(exp_b[s-1]));
      chk($sformatf("t3_C_sh%0d", s), 32'(C), 32'(exp_b[s-1]));
    end

    // compare-only subtract leaves R3 alone
    ext_write(3'd0, 16'h000F);
    ext_write(3'd1, 16'h000F);
    ext_write(3'd3, 16'h1234);
    c = '{2'b01, 3'd0, 3'd1, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0};
    run_cmd(c, 1'b0, 1'b0, 3'd0, 16'h0, de, ax, bx);
    chk("t4_C", 32'(C), 32'h0000);
    chk("t4_Z", 32'(Z), 32'd1);
    chk("t4_R3", 32'(dut.rf[3]), 32'h1234);

    // immediate path, WB beats a colliding external write
    c = '{2'b00, 3'd0, 3'd1, 3'd4, 2'b00, 1'b1, 1'b1, 5'b10110, 1'b1};
    run_cmd(c, 1'b0, 1'b1, 3'd4, 16'hABCD, de, ax, bx);
    chk("t5_Bin", 32'(bx), 32'hFFF6);
    chk("t5_C", 32'(C), 32'hFFF6);
    chk("t5_R4", 32'(dut.rf[4]), 32'hFFF6);
    // non-colliding external write on the WB edge also lands
    c.rd = 3'd7;
    run_cmd(c, 1'b0, 1'b1, 3'd6, 16'h5A5A, de, ax, bx);
    chk("t5_R7", 32'(dut.rf[7]), 32'hFFF6);
    chk("t5_R6", 32'(dut.rf[6]), 32'h5A5A);

    // cmd_valid held through WB must not restart at the WB edge
    c = '{2'b10, 3'd6, 3'd4, 3'd5, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1};
    run_cmd(c, 1'b1, 1'b0, 3'd0, 16'h0, de, ax, bx);
    chk("t6_ready_after_wb", 32'(cmd_ready), 32'd1);
    chk("t6_C", 32'(C), 32'h5A52);
    cmd_valid = 1'b0;
    @(posedge clk); #1;

    // reset in EXEC aborts the command
    ext_write(3'd0, 16'h0007);
    ext_write(3'd1, 16'h0001);
    c = '{2'b00, 3'd0, 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1};
    drive_cmd(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("t7_C", 32'(C), 32'h0000);
    chk("t7_done", 32'(done), 32'd0);
    chk("t7_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t7_R2", 32'(dut.rf[2]), 32'h0000);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      c.op    = 2'($urandom);
      c.rn    = 3'($urandom);
      c.rm    = 3'($urandom);
      c.rd    = 3'($urandom);
      c.shift = 2'($urandom);
      c.asel  = ($urandom_range(0, 3) == 0);
      c.bsel  = ($urandom_range(0, 3) == 0);
      c.imm   = 5'($urandom);
      c.wb    = ($urandom_range(0, 3) != 0);
      drive_cmd(c);
      cmd_valid = ($urandom_range(0, 2) != 0);
      ext_we    = ($urandom_range(0, 2) == 0);
      ext_waddr = 3'($urandom);
      ext_wdata = 16'($urandom);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    ext_we    = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
